// File: rtl/crp16_alu_issue_pkg.sv
// Constants shared by the CRP16 ALU-side blocks: operand/index widths and logic op codes.
`ifndef CRP16_ALU_ISSUE_PKG_SV
`define CRP16_ALU_ISSUE_PKG_SV
package crp16_alu_issue_pkg;
    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int CNT_W  = 4;

    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_OR  = 2'b01;
    localparam logic [1:0] LOGIC_NOT = 2'b10;
    localparam logic [1:0] LOGIC_XOR = 2'b11;
endpackage
`endif

// File: rtl/crp16_alu_issue_if.sv
// Bundle of the issue port, logic-unit drive/return and writeback port of crp16_alu_issue.
interface crp16_alu_issue_if;
    import crp16_alu_issue_pkg::*;

    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_code;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [REG_W-1:0]  op_dst;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [1:0]        alu_sel;
    logic [DATA_W-1:0] alu_out;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [REG_W-1:0]  wb_dst;
    logic              flag_z;
    logic              flag_n;

    // Both ports transfer on a rising edge where valid && ready; valid never depends on ready.
    modport slave (
        input  op_valid, op_code, op_a, op_b, op_dst, alu_out, wb_ready,
        output op_ready, alu_x, alu_y, alu_sel, wb_valid, wb_data, wb_dst, flag_z, flag_n
    );
    modport master (
        output op_valid, op_code, op_a, op_b, op_dst, alu_out, wb_ready,
        input  op_ready, alu_x, alu_y, alu_sel, wb_valid, wb_data, wb_dst, flag_z, flag_n
    );
endinterface

// File: rtl/crp16_exec_counter.sv
// Loadable 4-bit down-counter with zero flag; stops at zero.
module crp16_exec_counter
    import crp16_alu_issue_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
endmodule

// File: rtl/crp16_alu_issue.sv
// CRP16 logic-unit issue sequencer: IDLE -> EXEC (EXEC_CYCLES) -> WB.
// Optional flag registers are built when CRP16_ALU_ISSUE_FLAGS_EN is defined.
module crp16_alu_issue
    import crp16_alu_issue_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic               clock,
    input  logic               reset,
    crp16_alu_issue_if.slave   bus,
    output logic [1:0]         o_dbg_state
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_alu_x;
    logic [DATA_W-1:0] r_alu_y;
    logic [1:0]        r_alu_sel;
    logic [DATA_W-1:0] r_wb_data;
    logic [REG_W-1:0]  r_wb_dst;

    logic             w_accept;
    logic             w_wb_xfer;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_cnt;

    assign w_accept  = (r_state == ST_IDLE) && bus.op_valid;
    assign w_wb_xfer = (r_state == ST_WB) && bus.wb_ready;

    crp16_exec_counter u_cnt (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (EXEC_LOAD),
        .i_dec      (r_state == ST_EXEC),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_alu_x   <= '0;
            r_alu_y   <= '0;
            r_alu_sel <= LOGIC_AND;
            r_wb_data <= '0;
            r_wb_dst  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_x   <= bus.op_a;
                        r_alu_y   <= bus.op_b;
                        r_alu_sel <= bus.op_code;
                        r_wb_dst  <= bus.op_dst;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Count reaching zero marks the last cycle the operands are held.
                    if (w_cnt_zero) begin
                        r_wb_data <= bus.alu_out;
                        r_state   <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (w_wb_xfer) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CRP16_ALU_ISSUE_FLAGS_EN
    logic r_flag_z;
    logic r_flag_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_wb_xfer) begin
            r_flag_z <= (r_wb_data == '0);
            r_flag_n <= r_wb_data[DATA_W-1];
        end
    end

    assign bus.flag_z = r_flag_z;
    assign bus.flag_n = r_flag_n;
`else
    assign bus.flag_z = 1'b0;
    assign bus.flag_n = 1'b0;
`endif

    assign bus.op_ready = (r_state == ST_IDLE);
    assign bus.wb_valid = (r_state == ST_WB);
    assign bus.alu_x    = r_alu_x;
    assign bus.alu_y    = r_alu_y;
    assign bus.alu_sel  = r_alu_sel;
    assign bus.wb_data  = r_wb_data;
    assign bus.wb_dst   = r_wb_dst;
    assign o_dbg_state  = r_state;

    logic w_unused;
    assign w_unused = ^w_cnt;
endmodule

// File: tb/tb_crp16_alu_issue.sv
// Directed bench for crp16_alu_issue: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=4.
module tb_crp16_alu_issue;
    import crp16_alu_issue_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    crp16_alu_issue_if if1 ();
    crp16_alu_issue_if if4 ();
    logic [1:0] dbg1, dbg4;

    crp16_alu_issue #(.EXEC_CYCLES(1)) u_dut1 (.clock(clock), .reset(reset), .bus(if1), .o_dbg_state(dbg1));
    crp16_alu_issue #(.EXEC_CYCLES(4)) u_dut4 (.clock(clock), .reset(reset), .bus(if4), .o_dbg_state(dbg4));

    logic        op_valid1 = 1'b0, op_valid4 = 1'b0;
    logic        wb_ready1 = 1'b0, wb_ready4 = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [15:0] op_a = '0, op_b = '0;
    logic [2:0]  op_dst = '0;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    // Parent-level logic unit
    function automatic logic [15:0] logic_unit(input logic [15:0] x, input logic [15:0] y, input logic [1:0] sel);
        case (sel)
            LOGIC_AND: return x & y;
            LOGIC_OR:  return x | y;
            LOGIC_NOT: return ~x;
            default:   return x ^ y;
        endcase
    endfunction

    assign if1.op_valid = op_valid1;
    assign if1.op_code  = op_code;
    assign if1.op_a     = op_a;
    assign if1.op_b     = op_b;
    assign if1.op_dst   = op_dst;
    assign if1.wb_ready = wb_ready1;
    assign if1.alu_out  = logic_unit(if1.alu_x, if1.alu_y, if1.alu_sel);
    assign if4.op_valid = op_valid4;
    assign if4.op_code  = op_code;
    assign if4.op_a     = op_a;
    assign if4.op_b     = op_b;
    assign if4.op_dst   = op_dst;
    assign if4.wb_ready = wb_ready4;
    assign if4.alu_out  = logic_unit(if4.alu_x, if4.alu_y, if4.alu_sel);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic exp_z(input logic [15:0] d);
`ifdef CRP16_ALU_ISSUE_FLAGS_EN
        return (d == 16'h0000);
`else
        return 1'b0 & d[0];
`endif
    endfunction

    function automatic logic exp_n(input logic [15:0] d);
`ifdef CRP16_ALU_ISSUE_FLAGS_EN
        return d[15];
`else
        return 1'b0 & d[15];
`endif
    endfunction

    // One full operation on the EXEC_CYCLES=1 instance with the writeback sink ready.
    task automatic do_op1(input string tag, input logic [1:0] code, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] dst, input logic [15:0] exp_data);
        op_code = code; op_a = a; op_b = b; op_dst = dst;
        op_valid1 = 1'b1;
        exp_q.push_back(exp_data);
        tick();
        op_valid1 = 1'b0;
        check({tag, "_sel"}, 32'(if1.alu_sel), 32'(code));
        check({tag, "_x"}, 32'(if1.alu_x), 32'(a));
        check({tag, "_rdy_exec"}, 32'(if1.op_ready), 32'd0);
        check({tag, "_wbv_exec"}, 32'(if1.wb_valid), 32'd0);
        tick();
        check({tag, "_wbv"}, 32'(if1.wb_valid), 32'd1);
        check({tag, "_data"}, 32'(if1.wb_data), 32'(exp_q.pop_front()));
        check({tag, "_dst"}, 32'(if1.wb_dst), 32'(dst));
        wb_ready1 = 1'b1;
        tick();
        wb_ready1 = 1'b0;
        check({tag, "_rdy_after"}, 32'(if1.op_ready), 32'd1);
        check({tag, "_wbv_after"}, 32'(if1.wb_valid), 32'd0);
        check({tag, "_z"}, 32'(if1.flag_z), 32'(exp_z(exp_data)));
        check({tag, "_n"}, 32'(if1.flag_n), 32'(exp_n(exp_data)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb_seen;
        tick(); tick();
        reset = 1'b0;

        check("rst_state", 32'(dbg1), 32'd0);
        check("rst_ready", 32'(if1.op_ready), 32'd1);
        check("rst_wbv", 32'(if1.wb_valid), 32'd0);
        check("rst_x", 32'(if1.alu_x), 32'd0);
        check("rst_y", 32'(if1.alu_y), 32'd0);
        check("rst_sel", 32'(if1.alu_sel), 32'd0);
        check("rst_data", 32'(if1.wb_data), 32'd0);
        check("rst_dst", 32'(if1.wb_dst), 32'd0);
        check("rst_z", 32'(if1.flag_z), 32'd0);
        check("rst_n", 32'(if1.flag_n), 32'd0);

        do_op1("and", LOGIC_AND, 16'hF0F0, 16'h0FF0, 3'd3, 16'h00F0);
        do_op1("xor", LOGIC_XOR, 16'hAAAA, 16'hAAAA, 3'd5, 16'h0000);
        do_op1("not", LOGIC_NOT, 16'h00FF, 16'h1234, 3'd6, 16'hFF00);

        // Multi-cycle with backpressure on the EXEC_CYCLES=4 instance
        op_code = LOGIC_OR; op_a = 16'hF000; op_b = 16'h000F; op_dst = 3'd2;
        op_valid4 = 1'b1;
        tick();
        op_valid4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("mc_exec_x", 32'(if4.alu_x), 32'h0000F000);
            check("mc_exec_y", 32'(if4.alu_y), 32'h0000000F);
            check("mc_exec_sel", 32'(if4.alu_sel), 32'(LOGIC_OR));
            check("mc_exec_rdy", 32'(if4.op_ready), 32'd0);
            check("mc_exec_wbv", 32'(if4.wb_valid), 32'd0);
            op_a = 16'h1111; op_b = 16'h2222; op_code = LOGIC_AND; op_dst = 3'd7;
            op_valid4 = (i % 2 == 0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            check("mc_wb_wbv", 32'(if4.wb_valid), 32'd1);
            check("mc_wb_data", 32'(if4.wb_data), 32'h0000F00F);
            check("mc_wb_dst", 32'(if4.wb_dst), 32'd2);
            check("mc_wb_rdy", 32'(if4.op_ready), 32'd0);
            check("mc_wb_x", 32'(if4.alu_x), 32'h0000F000);
            op_valid4 = (i % 2 == 1);
            tick();
        end
        op_valid4 = 1'b0;
        wb_ready4 = 1'b1;
        tick();
        wb_ready4 = 1'b0;
        check("mc_rdy_after", 32'(if4.op_ready), 32'd1);
        check("mc_wbv_after", 32'(if4.wb_valid), 32'd0);
        check("mc_z", 32'(if4.flag_z), 32'(exp_z(16'hF00F)));
        check("mc_n", 32'(if4.flag_n), 32'(exp_n(16'hF00F)));

        // Reset in the second EXEC cycle drops the operation
        op_code = LOGIC_AND; op_a = 16'hFFFF; op_b = 16'hFFFF; op_dst = 3'd7;
        op_valid4 = 1'b1;
        tick();
        op_valid4 = 1'b0;
        tick();
        check("rm_in_exec", 32'(dbg4), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_state", 32'(dbg4), 32'd0);
        check("rm_ready", 32'(if4.op_ready), 32'd1);
        check("rm_wbv", 32'(if4.wb_valid), 32'd0);
        check("rm_x", 32'(if4.alu_x), 32'd0);
        check("rm_y", 32'(if4.alu_y), 32'd0);
        check("rm_sel", 32'(if4.alu_sel), 32'd0);
        check("rm_data", 32'(if4.wb_data), 32'd0);
        check("rm_dst", 32'(if4.wb_dst), 32'd0);
        check("rm_z", 32'(if4.flag_z), 32'd0);
        check("rm_n", 32'(if4.flag_n), 32'd0);
        wb_ready4 = 1'b1;
        wb_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (if4.wb_valid) wb_seen++;
            tick();
        end
        wb_ready4 = 1'b0;
        check("rm_no_wb", 32'(wb_seen), 32'd0);

        // Back-to-back on the reset-cleared EXEC_CYCLES=1 instance
        do_op1("not2", LOGIC_NOT, 16'h8000, 16'hFFFF, 3'd1, 16'h7FFF);
        do_op1("or2", LOGIC_OR, 16'h8001, 16'h0100, 3'd4, 16'h8101);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
